// File: rtl/snowf_collect_ctrl.sv
// Snowflake collect controller: edge-detects detector flags, tracks score,
// raises the all-collected flag and sequences the sparkle animation.
module snowf_collect_ctrl #(
    parameter int N_SNOWF        = 4,
    parameter int SPARKLE_FRAMES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SNOWF-1:0] snowf_get,
    input  logic               frame_tick,
    input  logic               level_restart,
    output logic               snowf_det_clr,
    output logic [N_SNOWF-1:0] snowf_visible,
    output logic [3:0]         snowf_count,
    output logic               collect_pulse,
    output logic               all_collected,
    output logic               win_pulse,
    output logic               sparkle_active,
    output logic [3:0]         sparkle_idx,
    output logic [3:0]         sparkle_frame
);

    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_SPARK = 1'b1;
    localparam logic [4:0] N_MAX   = 5'(N_SNOWF);
    localparam logic [3:0] F_LAST  = 4'(SPARKLE_FRAMES - 1);

    logic [N_SNOWF-1:0] prev_get_q, prev_get_d;
    logic [N_SNOWF-1:0] visible_q, visible_d;
    logic [3:0]         count_q, count_d;
    logic               collect_q, collect_d;
    logic               all_q, all_d;
    logic               win_q, win_d;
    logic               det_clr_q, det_clr_d;
    logic               state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         frame_q, frame_d;

    logic [N_SNOWF-1:0] rise;
    logic [4:0]         pop;
    logic [4:0]         sum;
    logic [3:0]         low_idx;
    logic               collect;

    assign rise    = snowf_get & ~prev_get_q & visible_q;
    assign collect = |rise;
    assign sum     = {1'b0, count_q} + pop;

    always_comb begin
        pop     = 5'd0;
        low_idx = 4'd0;
        for (int i = N_SNOWF - 1; i >= 0; i--) begin
            pop = pop + {4'd0, rise[i]};
            if (rise[i]) low_idx = 4'(i);
        end
    end

    always_comb begin
        prev_get_d = snowf_get;
        visible_d  = visible_q & ~rise;
        count_d    = (sum >= N_MAX) ? N_MAX[3:0] : sum[3:0];
        collect_d  = collect;
        all_d      = all_q | (count_d == N_MAX[3:0]);
        win_d      = all_d & ~all_q;
        det_clr_d  = 1'b0;
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;

        if (collect) begin
            state_d = S_SPARK;
            idx_d   = low_idx;
            frame_d = 4'd0;
        end else if (state_q == S_SPARK && frame_tick) begin
            if (frame_q == F_LAST) begin
                state_d = S_IDLE;
                frame_d = 4'd0;
            end else begin
                frame_d = frame_q + 4'd1;
            end
        end

        // Restart wins; old-level flags are masked by preloading prev_get.
        if (level_restart) begin
            prev_get_d = '1;
            visible_d  = '1;
            count_d    = 4'd0;
            collect_d  = 1'b0;
            all_d      = 1'b0;
            win_d      = 1'b0;
            det_clr_d  = 1'b1;
            state_d    = S_IDLE;
            idx_d      = 4'd0;
            frame_d    = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_get_q <= '1;
            visible_q  <= '1;
            count_q    <= 4'd0;
            collect_q  <= 1'b0;
            all_q      <= 1'b0;
            win_q      <= 1'b0;
            det_clr_q  <= 1'b1;
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            frame_q    <= 4'd0;
        end else begin
            prev_get_q <= prev_get_d;
            visible_q  <= visible_d;
            count_q    <= count_d;
            collect_q  <= collect_d;
            all_q      <= all_d;
            win_q      <= win_d;
            det_clr_q  <= det_clr_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
        end
    end

    assign snowf_det_clr  = det_clr_q;
    assign snowf_visible  = visible_q;
    assign snowf_count    = count_q;
    assign collect_pulse  = collect_q;
    assign all_collected  = all_q;
    assign win_pulse      = win_q;
    assign sparkle_active = (state_q == S_SPARK);
    assign sparkle_idx    = idx_q;
    assign sparkle_frame  = frame_q;

endmodule

// File: tb/tb_snowf_collect_ctrl.sv
// Directed table-driven bench for snowf_collect_ctrl (N_SNOWF=4, 6 frames).
module tb_snowf_collect_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] snowf_get;
    logic       frame_tick;
    logic       level_restart;
    logic       snowf_det_clr;
    logic [3:0] snowf_visible;
    logic [3:0] snowf_count;
    logic       collect_pulse;
    logic       all_collected;
    logic       win_pulse;
    logic       sparkle_active;
    logic [3:0] sparkle_idx;
    logic [3:0] sparkle_frame;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    snowf_collect_ctrl #(.N_SNOWF(4), .SPARKLE_FRAMES(6)) dut (
        .clk(clk), .reset(reset), .snowf_get(snowf_get),
        .frame_tick(frame_tick), .level_restart(level_restart),
        .snowf_det_clr(snowf_det_clr), .snowf_visible(snowf_visible),
        .snowf_count(snowf_count), .collect_pulse(collect_pulse),
        .all_collected(all_collected), .win_pulse(win_pulse),
        .sparkle_active(sparkle_active), .sparkle_idx(sparkle_idx),
        .sparkle_frame(sparkle_frame)
    );

    typedef struct {
        logic [3:0]  get;
        logic        tick;
        logic        rst;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[26];

    // Packed order: vis, cnt, col, all, win, act, idx, frm, clr
    function automatic logic [20:0] ex(
        input logic [3:0] vis, input logic [3:0] cnt, input logic col,
        input logic all, input logic win, input logic act,
        input logic [3:0] idx, input logic [3:0] frm, input logic clr);
        return {vis, cnt, col, all, win, act, idx, frm, clr};
    endfunction

    function automatic logic [20:0] outs();
        return {snowf_visible, snowf_count, collect_pulse, all_collected,
                win_pulse, sparkle_active, sparkle_idx, sparkle_frame,
                snowf_det_clr};
    endfunction

    task automatic check(input string name, input logic [20:0] exp);
        logic [20:0] act;
        act = outs();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] g, input logic t,
                        input logic r, input logic [20:0] e);
        vecs[i].get  = g;
        vecs[i].tick = t;
        vecs[i].rst  = r;
        vecs[i].exp  = e;
    endtask

    initial begin
        setv(0,  4'h0, 0, 0, ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(1,  4'h4, 0, 0, ex(4'hB, 1, 1, 0, 0, 1, 2, 0, 0));
        setv(2,  4'h4, 0, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 0, 0));
        setv(3,  4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 1, 0));
        setv(4,  4'h4, 0, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 1, 0));
        setv(5,  4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 2, 0));
        setv(6,  4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 3, 0));
        setv(7,  4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 4, 0));
        setv(8,  4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 1, 2, 5, 0));
        setv(9,  4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 0, 2, 0, 0));
        setv(10, 4'h4, 1, 0, ex(4'hB, 1, 0, 0, 0, 0, 2, 0, 0));
        setv(11, 4'hD, 0, 0, ex(4'h2, 3, 1, 0, 0, 1, 0, 0, 0));
        setv(12, 4'hF, 0, 0, ex(4'h0, 4, 1, 1, 1, 1, 1, 0, 0));
        setv(13, 4'hF, 0, 0, ex(4'h0, 4, 0, 1, 0, 1, 1, 0, 0));
        setv(14, 4'hF, 0, 1, ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
        setv(15, 4'hF, 0, 0, ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(16, 4'h0, 0, 0, ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(17, 4'h2, 0, 0, ex(4'hD, 1, 1, 0, 0, 1, 1, 0, 0));
        setv(18, 4'h2, 1, 0, ex(4'hD, 1, 0, 0, 0, 1, 1, 1, 0));
        setv(19, 4'h2, 1, 0, ex(4'hD, 1, 0, 0, 0, 1, 1, 2, 0));
        setv(20, 4'h2, 1, 0, ex(4'hD, 1, 0, 0, 0, 1, 1, 3, 0));
        setv(21, 4'h6, 1, 0, ex(4'h9, 2, 1, 0, 0, 1, 2, 0, 0));
        setv(22, 4'h6, 1, 0, ex(4'h9, 2, 0, 0, 0, 1, 2, 1, 0));
        setv(23, 4'h7, 0, 1, ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
        setv(24, 4'h0, 0, 0, ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        setv(25, 4'h7, 0, 0, ex(4'h8, 3, 1, 0, 0, 1, 0, 0, 0));

        reset = 1'b0;
        snowf_get = 4'h0;
        frame_tick = 1'b0;
        level_restart = 1'b0;
        @(negedge clk);
        check("reset", ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b1;

        for (int i = 0; i < 26; i++) begin
            snowf_get     = vecs[i].get;
            frame_tick    = vecs[i].tick;
            level_restart = vecs[i].rst;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        frame_tick = 1'b0;

        // Asynchronous reset mid-cycle while sparkling with count 3
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_rst", ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst", ex(4'hF, 0, 0, 0, 0, 0, 0, 0, 0));

        // Full sparkle run with ticks ten cycles apart
        snowf_get = 4'h0;
        @(negedge clk);
        snowf_get = 4'h8;
        @(negedge clk);
        check("spk_start", ex(4'h7, 1, 1, 0, 0, 1, 3, 0, 0));
        for (int t = 1; t <= 6; t++) begin
            repeat (9) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            check($sformatf("spk_tick%0d", t),
                  ex(4'h7, 1, 0, 0, 0, (t < 6) ? 1'b1 : 1'b0, 3,
                     (t < 6) ? 4'(t) : 4'd0, 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
